// File: rtl/ahb_cfg_slave.sv
// ahb_cfg_slave: AHB-Lite configuration slave for the edge-detection accelerator.
// Holds NUM_CFG config words plus CTRL/STATUS, runs the start/busy/done job
// handshake with the core and raises a level interrupt when a job finishes.
// Zero-wait-state OKAY transfers; faulting transfers get a two-cycle ERROR.
module ahb_cfg_slave #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int NUM_CFG = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSEL,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [DATA_W-1:0]         HWDATA,
    input  logic                      HREADY,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [NUM_CFG*DATA_W-1:0] cfg_out,
    output logic                      start,
    input  logic                      core_busy,
    input  logic                      core_done,
    output logic                      irq
);

    localparam int OFF_W = ADDR_W - 2;
    localparam logic [OFF_W-1:0] CTRL_OFF = OFF_W'(NUM_CFG);
    localparam logic [OFF_W-1:0] STAT_OFF = OFF_W'(NUM_CFG + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Address-phase capture for the data phase
    logic             dph_vld;
    logic             dph_wr;
    logic [2:0]       dph_size;
    logic [OFF_W-1:0] dph_off;
    logic             err2;

    logic [NUM_CFG-1:0][DATA_W-1:0] cfg_q;
    logic irq_en;
    logic err_flag;

    logic addr_acc;
    logic is_cfg, is_ctrl, is_stat, mapped;
    logic dph_err;
    logic wr_ok, ctrl_we, stat_we;
    logic go, done_clr;
    logic start_d, irq_d;
    logic st_run, st_done;
    logic [DATA_W-1:0] rd_mux;

    // HADDR[1:0] and HTRANS[0] carry no information for a word-only slave
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HADDR[1:0]};

    assign addr_acc = HSEL & HREADY & HTRANS[1];

    assign is_cfg  = (dph_off < CTRL_OFF);
    assign is_ctrl = (dph_off == CTRL_OFF);
    assign is_stat = (dph_off == STAT_OFF);
    assign mapped  = is_cfg | is_ctrl | is_stat;

    // Error is judged in the data phase so that a job started by the previous
    // transfer already protects the config registers
    assign dph_err = dph_vld & ((dph_size != 3'b010) | ~mapped |
                                (dph_wr & (is_cfg | is_ctrl) & (state == ST_RUN)));

    assign wr_ok    = dph_vld & dph_wr & ~dph_err;
    assign ctrl_we  = wr_ok & is_ctrl;
    assign stat_we  = wr_ok & is_stat;
    assign go       = ctrl_we & HWDATA[0];
    assign done_clr = stat_we & HWDATA[1];

    assign HREADYOUT = ~dph_err;
    assign HRESP     = dph_err | err2;
    assign cfg_out   = cfg_q;

    // Capture address-phase controls; an erroring data phase retires itself
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_vld  <= 1'b0;
            dph_wr   <= 1'b0;
            dph_size <= 3'b000;
            dph_off  <= '0;
            err2     <= 1'b0;
        end else begin
            dph_vld <= HREADY ? addr_acc : (dph_vld & ~dph_err);
            err2    <= dph_err;
            if (addr_acc) begin
                dph_wr   <= HWRITE;
                dph_size <= HSIZE;
                dph_off  <= HADDR[ADDR_W-1:2];
            end
        end
    end

    // Config register bank, one word per generate slot
    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn)
                cfg_q[k] <= '0;
            else if (wr_ok && dph_off == OFF_W'(k))
                cfg_q[k] <= HWDATA;
        end
    end

    // IRQ enable and sticky error flag; a new error beats a same-cycle W1C
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_en   <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (ctrl_we)
                irq_en <= HWDATA[1];
            if (dph_err)
                err_flag <= 1'b1;
            else if (stat_we && HWDATA[2])
                err_flag <= 1'b0;
        end
    end

    // Job FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Job FSM next state; GO is only reachable outside RUN (RUN writes fault)
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go) state_nxt = ST_RUN;
            ST_RUN:  if (core_done) state_nxt = ST_DONE;
            ST_DONE: begin
                if (go)
                    state_nxt = ST_RUN;
                else if (done_clr)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job FSM outputs: status bits and the pre-register start/irq values
    always_comb begin
        st_run  = (state == ST_RUN);
        st_done = (state == ST_DONE);
        start_d = go;
        irq_d   = st_done & irq_en;
    end

    // Registered start pulse and interrupt
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            start <= 1'b0;
            irq   <= 1'b0;
        end else begin
            start <= start_d;
            irq   <= irq_d;
        end
    end

    // Read mux over registered state; zero outside an OKAY read data phase
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CFG; k++)
            if (dph_off == OFF_W'(k))
                rd_mux = cfg_q[k];
        if (is_ctrl)
            rd_mux = {{(DATA_W-2){1'b0}}, irq_en, 1'b0};
        if (is_stat)
            rd_mux = {{(DATA_W-6){1'b0}}, state, core_busy, err_flag, st_done, st_run};
        HRDATA = (dph_vld && !dph_wr && !dph_err) ? rd_mux : '0;
    end

endmodule
